// File: rtl/phase_acc_gen_if.sv
// FTW load handshake between a tuning-word source and phase_acc_gen.
// The source drives word/valid; the accumulator answers with ready.
interface phase_acc_gen_if #(
   parameter int ACC_W = 24
);
   logic [ACC_W-1:0] ftw_in;
   logic             ftw_valid;
   logic             ftw_ready;

   modport master (
      output ftw_in,
      output ftw_valid,
      input  ftw_ready
   );

   modport slave (
      input  ftw_in,
      input  ftw_valid,
      output ftw_ready
   );
endinterface

// File: rtl/phase_acc_gen.sv
// NCO phase accumulator for the waveform generators.
// Free-run and N-period burst modes; FTW changes land on a phase wrap.
module phase_acc_gen #(
   parameter int             ACC_W   = 24,
   parameter logic [ACC_W-1:0] FTW_RST = '0
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 en,
   input  logic                 run_en,
   input  logic                 burst_start,
   input  logic [7:0]           burst_len,
   input  logic                 sync,
   phase_acc_gen_if.slave       ftw,
   input  logic [7:0]           phase_off,
   output logic [7:0]           phase,
   output logic                 wrap,
   output logic                 busy,
   output logic                 burst_done
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      BURST = 2'd2
   } state_t;

   state_t           state, st_n;
   logic [ACC_W-1:0] acc, acc_n;
   logic [ACC_W-1:0] ftw_act;
   logic [ACC_W-1:0] pend;
   logic             pend_valid;
   logic [7:0]       burst_cnt, cnt_n;
   logic [ACC_W:0]   sum;
   logic             wrap_n;
   logic             done_n;
   logic             accept;
   logic             apply;
   logic [7:0]       phase_n;

   assign sum = {1'b0, acc} + {1'b0, ftw_act};

   assign ftw.ftw_ready = !rst && !pend_valid;
   assign accept        = ftw.ftw_valid && ftw.ftw_ready;

   always_comb begin
      st_n   = state;
      acc_n  = acc;
      wrap_n = 1'b0;
      done_n = 1'b0;
      cnt_n  = burst_cnt;
      if (sync && state != IDLE) begin
         acc_n = '0;
      end else begin
         unique case (state)
            IDLE: begin
               acc_n = '0;
               if (run_en) begin
                  st_n = RUN;
               end else if (burst_start && burst_len != 8'd0) begin
                  st_n  = BURST;
                  cnt_n = burst_len;
               end
            end
            RUN: begin
               if (!run_en) begin
                  st_n  = IDLE;
                  acc_n = '0;
               end else if (en) begin
                  acc_n  = sum[ACC_W-1:0];
                  wrap_n = sum[ACC_W];
               end
            end
            BURST: begin
               if (en) begin
                  acc_n  = sum[ACC_W-1:0];
                  wrap_n = sum[ACC_W];
                  if (sum[ACC_W]) begin
                     cnt_n = burst_cnt - 8'd1;
                     // last period: return to IDLE in the wrap cycle
                     if (burst_cnt == 8'd1) begin
                        st_n   = IDLE;
                        acc_n  = '0;
                        done_n = 1'b1;
                     end
                  end
               end
            end
            default: begin
               st_n  = IDLE;
               acc_n = '0;
            end
         endcase
      end
   end

   // pending word lands on a wrap or when the generator stops
   assign apply = pend_valid &&
                  (wrap_n || (state != IDLE && st_n == IDLE));

   assign phase_n = acc_n[ACC_W-1 -: 8] + phase_off;

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         acc        <= '0;
         phase      <= 8'd0;
         wrap       <= 1'b0;
         busy       <= 1'b0;
         burst_done <= 1'b0;
         ftw_act    <= FTW_RST;
         pend       <= '0;
         pend_valid <= 1'b0;
         burst_cnt  <= 8'd0;
      end else begin
         state      <= st_n;
         acc        <= acc_n;
         phase      <= phase_n;
         wrap       <= wrap_n;
         busy       <= (st_n != IDLE);
         burst_done <= done_n;
         burst_cnt  <= cnt_n;
         if (apply) begin
            ftw_act    <= pend;
            pend_valid <= 1'b0;
         end else if (accept) begin
            if (state == IDLE || ftw_act == '0) begin
               ftw_act <= ftw.ftw_in;
            end else begin
               pend       <= ftw.ftw_in;
               pend_valid <= 1'b1;
            end
         end
      end
   end

endmodule
